// File: rtl/dfr_pkg.sv
// Shared types and constants for the DFR run sequencer.
package dfr_pkg;

   localparam int DFR_ADDR_WIDTH = 16;
   localparam int DFR_CNT_WIDTH  = 32;

   localparam int DBG_STATE_LSB = 28;
   localparam int DBG_ERR_BIT   = 27;
   localparam int DBG_IDX_W     = 16;

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_LATCH   = 4'd1,
      S_RD      = 4'd2,
      S_STEP    = 4'd3,
      S_DP      = 4'd4,
      S_DP_WAIT = 4'd5,
      S_OUT_WR  = 4'd6,
      S_DONE    = 4'd7
   } state_t;

   typedef enum logic [1:0] {
      PH_IDLE  = 2'd0,
      PH_INIT  = 2'd1,
      PH_TRAIN = 2'd2,
      PH_TEST  = 2'd3
   } phase_t;

   // First phase after cur whose sample count is nonzero; PH_IDLE when none remain.
   function automatic phase_t next_phase(input phase_t cur, input logic init_nz,
                                         input logic train_nz, input logic test_nz);
      phase_t nxt;
      nxt = PH_IDLE;
      if (cur == PH_IDLE && init_nz)
         nxt = PH_INIT;
      else if ((cur == PH_IDLE || cur == PH_INIT) && train_nz)
         nxt = PH_TRAIN;
      else if (cur != PH_TEST && test_nz)
         nxt = PH_TEST;
      return nxt;
   endfunction

endpackage

// File: rtl/dfr_step_counter.sv
// Nested sample/step counter; the parent supplies the sample count of the current phase.
module dfr_step_counter #(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 S_AXI_ACLK,
   input  logic                 S_AXI_ARESETN,
   input  logic                 load,
   input  logic                 inc,
   input  logic [CNT_WIDTH-1:0] num_steps,
   input  logic [CNT_WIDTH-1:0] num_samples,
   output logic [CNT_WIDTH-1:0] sample_idx,
   output logic                 last_step,
   output logic                 last_sample
);

   localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

   logic [CNT_WIDTH-1:0] step_idx;

   assign last_step   = (step_idx == num_steps - ONE);
   assign last_sample = (sample_idx == num_samples - ONE);

   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         step_idx   <= '0;
         sample_idx <= '0;
      end else if (load) begin
         step_idx   <= '0;
         sample_idx <= '0;
      end else if (inc) begin
         if (last_step) begin
            step_idx   <= '0;
            sample_idx <= last_sample ? '0 : sample_idx + ONE;
         end else begin
            step_idx <= step_idx + ONE;
         end
      end
   end

endmodule

// File: rtl/dfr_run_sequencer.sv
// DFR run sequencer: walks init/train/test phases, stepping the reservoir and launching readout.
// Optional abort input is enabled by defining DFR_SEQ_ABORT_EN.
//
// state   | meaning
// IDLE    | wait for a rising edge of start
// LATCH   | counts captured; pick first phase or finish
// RD      | input memory read at the global step index
// STEP    | reservoir step request; history write on accept
// DP      | dot-product launch pulse
// DP_WAIT | wait for dot-product result
// OUT_WR  | write result for the current test sample
// DONE    | one-cycle done pulse
module dfr_run_sequencer
   import dfr_pkg::*;
#(
   parameter int ADDR_WIDTH = DFR_ADDR_WIDTH,
   parameter int CNT_WIDTH  = DFR_CNT_WIDTH
) (
   input  logic                  S_AXI_ACLK,
   input  logic                  S_AXI_ARESETN,
   input  logic                  start,
   input  logic [CNT_WIDTH-1:0]  num_init_samples,
   input  logic [CNT_WIDTH-1:0]  num_train_samples,
   input  logic [CNT_WIDTH-1:0]  num_test_samples,
   input  logic [CNT_WIDTH-1:0]  num_steps_per_sample,
`ifdef DFR_SEQ_ABORT_EN
   input  logic                  abort,
`endif
   output logic                  busy,
   output logic                  done,
   output logic                  in_mem_rd,
   output logic [ADDR_WIDTH-1:0] in_mem_addr,
   output logic                  res_step_valid,
   input  logic                  res_step_ready,
   output logic                  hist_wr,
   output logic [ADDR_WIDTH-1:0] hist_addr,
   output logic                  dp_start,
   input  logic                  dp_done,
   output logic                  out_mem_wr,
   output logic [ADDR_WIDTH-1:0] out_mem_addr,
   output logic [1:0]            phase,
   output logic [31:0]           debug
);

   state_t                state_q, state_d;
   phase_t                phase_q, phase_d, nxt_phase;
   logic                  start_q, launch, any_samples;
   logic                  err_q, set_err, cnt_inc, step_acc, abort_hit;
   logic [CNT_WIDTH-1:0]  init_q, train_q, test_q, steps_q, cur_samples;
   logic [ADDR_WIDTH-1:0] gstep_q, hist_q;
   logic [CNT_WIDTH-1:0]  sample_idx;
   logic                  last_step, last_sample;

`ifdef DFR_SEQ_ABORT_EN
   assign abort_hit = abort && (state_q != S_IDLE) && (state_q != S_DONE);
`else
   assign abort_hit = 1'b0;
`endif

   assign launch      = (state_q == S_IDLE) && start && !start_q;
   assign any_samples = (init_q != '0) || (train_q != '0) || (test_q != '0);
   assign nxt_phase   = next_phase(phase_q, init_q != '0, train_q != '0, test_q != '0);

   always_comb begin
      case (phase_q)
         PH_INIT:  cur_samples = init_q;
         PH_TRAIN: cur_samples = train_q;
         PH_TEST:  cur_samples = test_q;
         default:  cur_samples = '0;
      endcase
   end

   dfr_step_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
      .S_AXI_ACLK    (S_AXI_ACLK),
      .S_AXI_ARESETN (S_AXI_ARESETN),
      .load          (launch),
      .inc           (cnt_inc),
      .num_steps     (steps_q),
      .num_samples   (cur_samples),
      .sample_idx    (sample_idx),
      .last_step     (last_step),
      .last_sample   (last_sample)
   );

   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d        = state_q;
      phase_d        = phase_q;
      set_err        = 1'b0;
      cnt_inc        = 1'b0;
      step_acc       = 1'b0;
      busy           = 1'b0;
      done           = 1'b0;
      in_mem_rd      = 1'b0;
      res_step_valid = 1'b0;
      hist_wr        = 1'b0;
      dp_start       = 1'b0;
      out_mem_wr     = 1'b0;
      case (state_q)
         S_IDLE: if (launch) state_d = S_LATCH;
         S_LATCH: begin
            busy = 1'b1;
            if (!any_samples) begin
               state_d = S_DONE;
            end else if (steps_q == '0) begin
               state_d = S_DONE;
               set_err = 1'b1;
            end else begin
               state_d = S_RD;
               phase_d = nxt_phase;
            end
         end
         S_RD: begin
            busy      = 1'b1;
            in_mem_rd = 1'b1;
            state_d   = S_STEP;
         end
         S_STEP: begin
            busy           = 1'b1;
            res_step_valid = 1'b1;
            if (res_step_ready) begin
               step_acc = 1'b1;
               hist_wr  = (phase_q != PH_INIT);
               if (!last_step) begin
                  cnt_inc = 1'b1;
                  state_d = S_RD;
               end else if (phase_q == PH_TEST) begin
                  // test samples advance only after their result is written
                  state_d = S_DP;
               end else begin
                  cnt_inc = 1'b1;
                  if (!last_sample) begin
                     state_d = S_RD;
                  end else if (nxt_phase == PH_IDLE) begin
                     state_d = S_DONE;
                  end else begin
                     phase_d = nxt_phase;
                     state_d = S_RD;
                  end
               end
            end
         end
         S_DP: begin
            busy     = 1'b1;
            dp_start = 1'b1;
            state_d  = S_DP_WAIT;
         end
         S_DP_WAIT: begin
            busy = 1'b1;
            if (dp_done) state_d = S_OUT_WR;
         end
         S_OUT_WR: begin
            busy       = 1'b1;
            out_mem_wr = 1'b1;
            cnt_inc    = 1'b1;
            state_d    = last_sample ? S_DONE : S_RD;
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      if (abort_hit) begin
         state_d        = S_DONE;
         set_err        = 1'b1;
         cnt_inc        = 1'b0;
         step_acc       = 1'b0;
         res_step_valid = 1'b0;
         hist_wr        = 1'b0;
      end
      if (state_d == S_DONE) phase_d = PH_IDLE;
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (!S_AXI_ARESETN) begin
         start_q <= 1'b0;
         phase_q <= PH_IDLE;
         err_q   <= 1'b0;
         init_q  <= '0;
         train_q <= '0;
         test_q  <= '0;
         steps_q <= '0;
         gstep_q <= '0;
         hist_q  <= '0;
      end else begin
         start_q <= start;
         phase_q <= phase_d;
         if (launch) begin
            init_q  <= num_init_samples;
            train_q <= num_train_samples;
            test_q  <= num_test_samples;
            steps_q <= num_steps_per_sample;
            err_q   <= 1'b0;
            gstep_q <= '0;
            hist_q  <= '0;
         end else begin
            if (set_err) err_q <= 1'b1;
            if (step_acc) begin
               gstep_q <= gstep_q + ADDR_WIDTH'(1);
               if (phase_q != PH_INIT) hist_q <= hist_q + ADDR_WIDTH'(1);
            end
         end
      end
   end

   assign in_mem_addr  = gstep_q;
   assign hist_addr    = hist_q;
   assign out_mem_addr = ADDR_WIDTH'(sample_idx);
   assign phase        = phase_q;

   always_comb begin
      debug                        = '0;
      debug[DBG_STATE_LSB +: 4]    = state_q;
      debug[DBG_ERR_BIT]           = err_q;
      if (phase_q == PH_TEST)
         debug[DBG_IDX_W-1:0] = DBG_IDX_W'(sample_idx);
   end

endmodule

// File: tb/tb_dfr_run_sequencer.sv
// Self-checking bench for dfr_run_sequencer: directed scenarios plus randomized runs against an event model.
module tb_dfr_run_sequencer;

   localparam int AW = 16;
   localparam int CW = 32;

   logic          S_AXI_ACLK = 1'b0;
   logic          S_AXI_ARESETN = 1'b0;
   logic          start = 1'b0;
   logic [CW-1:0] num_init_samples = '0;
   logic [CW-1:0] num_train_samples = '0;
   logic [CW-1:0] num_test_samples = '0;
   logic [CW-1:0] num_steps_per_sample = '0;
   logic          busy, done, in_mem_rd, res_step_valid, hist_wr, dp_start, out_mem_wr;
   logic          res_step_ready = 1'b0;
   logic          dp_done = 1'b0;
   logic [AW-1:0] in_mem_addr, hist_addr, out_mem_addr;
   logic [1:0]    phase;
   logic [31:0]   debug;
`ifdef DFR_SEQ_ABORT_EN
   logic          abort = 1'b0;
`endif

   dfr_run_sequencer dut (
      .S_AXI_ACLK           (S_AXI_ACLK),
      .S_AXI_ARESETN        (S_AXI_ARESETN),
      .start                (start),
      .num_init_samples     (num_init_samples),
      .num_train_samples    (num_train_samples),
      .num_test_samples     (num_test_samples),
      .num_steps_per_sample (num_steps_per_sample),
`ifdef DFR_SEQ_ABORT_EN
      .abort                (abort),
`endif
      .busy                 (busy),
      .done                 (done),
      .in_mem_rd            (in_mem_rd),
      .in_mem_addr          (in_mem_addr),
      .res_step_valid       (res_step_valid),
      .res_step_ready       (res_step_ready),
      .hist_wr              (hist_wr),
      .hist_addr            (hist_addr),
      .dp_start             (dp_start),
      .dp_done              (dp_done),
      .out_mem_wr           (out_mem_wr),
      .out_mem_addr         (out_mem_addr),
      .phase                (phase),
      .debug                (debug)
   );

   always #5 S_AXI_ACLK = ~S_AXI_ACLK;

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // Reservoir / dot-product responder, driven just after each rising edge.
   int stall_addr = -1;
   int stall_left = 0;
   bit rand_ready = 1'b0;
   bit rand_dp    = 1'b0;
   initial forever begin
      @(posedge S_AXI_ACLK);
      #1;
      if (res_step_valid && stall_left > 0 && int'(in_mem_addr) == stall_addr) begin
         res_step_ready = 1'b0;
         stall_left--;
      end else begin
         res_step_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      dp_done = rand_dp ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Event monitor, sampling on the falling edge.
   int q_in[$], q_hist[$], q_hist_g[$], q_out[$], q_out_dp[$], q_phase[$];
   int dp_cnt = 0;
   int done_cnt = 0;
   logic [1:0] last_phase = 2'd0;
   initial forever begin
      @(negedge S_AXI_ACLK);
      if (in_mem_rd) q_in.push_back(int'(in_mem_addr));
      if (hist_wr) begin
         q_hist.push_back(int'(hist_addr));
         q_hist_g.push_back(int'(in_mem_addr));
      end
      if (dp_start) dp_cnt++;
      if (out_mem_wr) begin
         q_out.push_back(int'(out_mem_addr));
         q_out_dp.push_back(dp_cnt);
      end
      if (done) done_cnt++;
      if (phase !== last_phase && phase !== 2'd0) q_phase.push_back(int'(phase));
      last_phase = phase;
   end

   task automatic clear_mon();
      q_in.delete(); q_hist.delete(); q_hist_g.delete();
      q_out.delete(); q_out_dp.delete(); q_phase.delete();
      dp_cnt = 0;
      done_cnt = 0;
   endtask

   task automatic launch(input string tag, input int i, input int t, input int e, input int s);
      clear_mon();
      num_init_samples     = CW'(i);
      num_train_samples    = CW'(t);
      num_test_samples     = CW'(e);
      num_steps_per_sample = CW'(s);
      start = 1'b0;
      @(negedge S_AXI_ACLK);
      start = 1'b1;
      @(negedge S_AXI_ACLK);
      chk({tag, "_busy_latch"}, busy, 1'b1);
      // counts must have been captured already; scramble the live inputs
      num_init_samples     = $urandom;
      num_train_samples    = $urandom;
      num_test_samples     = $urandom;
      num_steps_per_sample = $urandom;
   endtask

   int   w_lat;
   logic w_seen, w_err, w_busy;
   logic [1:0] w_phase;
   task automatic wait_done(input string tag);
      w_seen = 1'b0;
      w_lat = 0;
      for (int c = 1; c <= 20000; c++) begin
         @(negedge S_AXI_ACLK);
         if (done === 1'b1) begin
            w_seen  = 1'b1;
            w_lat   = c;
            w_err   = debug[27];
            w_busy  = busy;
            w_phase = phase;
            break;
         end
      end
      chk({tag, "_done_seen"}, w_seen, 1'b1);
      repeat (3) @(negedge S_AXI_ACLK);
   endtask

   task automatic check_run(input string tag, input int i, input int t, input int e, input int s);
      bit active;
      int n_in, n_hist, n_out, bad;
      int exp_ph[$];
      active = (i + t + e != 0) && (s != 0);
      n_in   = active ? (i + t + e) * s : 0;
      n_hist = active ? (t + e) * s : 0;
      n_out  = active ? e : 0;
      chk({tag, "_err"}, w_err, (s == 0 && i + t + e != 0));
      chk({tag, "_busy_phase_at_done"}, {w_busy, w_phase}, 3'd0);
      chk({tag, "_done_count"}, done_cnt, 1);
      chk({tag, "_in_count"}, q_in.size(), n_in);
      bad = 0;
      foreach (q_in[k]) if (q_in[k] != k % 65536) bad++;
      chk({tag, "_in_addr_seq"}, bad, 0);
      chk({tag, "_hist_count"}, q_hist.size(), n_hist);
      bad = 0;
      foreach (q_hist[k])
         if (q_hist[k] != k % 65536 || q_hist_g[k] < i * s ||
             q_hist[k] != ((q_hist_g[k] - i * s) & 32'hffff)) bad++;
      chk({tag, "_hist_addr_map"}, bad, 0);
      chk({tag, "_dp_count"}, dp_cnt, n_out);
      chk({tag, "_out_count"}, q_out.size(), n_out);
      bad = 0;
      foreach (q_out[k]) if (q_out[k] != k || q_out_dp[k] != k + 1) bad++;
      chk({tag, "_out_addr_seq"}, bad, 0);
      if (active) begin
         if (i > 0) exp_ph.push_back(1);
         if (t > 0) exp_ph.push_back(2);
         if (e > 0) exp_ph.push_back(3);
      end
      bad = (q_phase.size() == exp_ph.size()) ? 0 : 1;
      if (bad == 0) foreach (exp_ph[k]) if (q_phase[k] != exp_ph[k]) bad++;
      chk({tag, "_phase_seq"}, bad, 0);
   endtask

   initial begin
      int ri, rt, re, rs;
      bit found;
      int stall_bad;
      logic busy_seen;

      repeat (3) @(negedge S_AXI_ACLK);
      chk("rst_strobes", {busy, done, in_mem_rd, res_step_valid, hist_wr, dp_start, out_mem_wr}, 7'd0);
      chk("rst_addrs", {in_mem_addr, hist_addr, out_mem_addr}, 48'd0);
      chk("rst_phase_debug", {phase, debug}, 34'd0);
      S_AXI_ARESETN = 1'b1;
      @(negedge S_AXI_ACLK);

      launch("runA", 0, 0, 1, 100);
      wait_done("runA");
      check_run("runA", 0, 0, 1, 100);

      launch("runB", 1, 0, 2, 4);
      wait_done("runB");
      check_run("runB", 1, 0, 2, 4);

      launch("zero", 0, 0, 0, 5);
      wait_done("zero");
      chk("zero_done_latency", w_lat, 1);
      check_run("zero", 0, 0, 0, 5);

      launch("steps0", 0, 0, 1, 0);
      wait_done("steps0");
      chk("steps0_done_latency", w_lat, 1);
      check_run("steps0", 0, 0, 1, 0);

      // start stays high after done: no relaunch
      clear_mon();
      busy_seen = 1'b0;
      repeat (20) begin
         @(negedge S_AXI_ACLK);
         busy_seen = busy_seen | busy;
      end
      chk("held_start_no_busy", busy_seen, 1'b0);
      chk("held_start_no_rd", q_in.size(), 0);
      launch("relaunch", 2, 1, 1, 3);
      wait_done("relaunch");
      check_run("relaunch", 2, 1, 1, 3);

      // reservoir stalls 50 cycles on step 5
      stall_addr = 5;
      stall_left = 50;
      launch("stall", 0, 0, 1, 10);
      found = 1'b0;
      for (int c = 0; c < 200 && !found; c++) begin
         @(negedge S_AXI_ACLK);
         if (res_step_valid && in_mem_addr == 16'd5) found = 1'b1;
      end
      chk("stall_reached", found, 1'b1);
      stall_bad = 0;
      for (int c = 0; c < 50; c++) begin
         if (c > 0) @(negedge S_AXI_ACLK);
         if ({res_step_valid, in_mem_rd, hist_wr} !== 3'b100 ||
             in_mem_addr !== 16'd5 || hist_addr !== 16'd5) stall_bad++;
      end
      chk("stall_hold_stable", stall_bad, 0);
      wait_done("stall");
      check_run("stall", 0, 0, 1, 10);
      stall_left = 0;

      // reset in the middle of a run
      launch("abortrst", 0, 0, 1, 100);
      found = 1'b0;
      for (int c = 0; c < 500 && !found; c++) begin
         @(negedge S_AXI_ACLK);
         if (in_mem_rd && in_mem_addr == 16'd37) found = 1'b1;
      end
      chk("midrst_reached", found, 1'b1);
      S_AXI_ARESETN = 1'b0;
      start = 1'b0;
      @(negedge S_AXI_ACLK);
      chk("midrst_strobes", {busy, done, in_mem_rd, res_step_valid, hist_wr, dp_start, out_mem_wr}, 7'd0);
      chk("midrst_addrs", {in_mem_addr, hist_addr, out_mem_addr}, 48'd0);
      chk("midrst_phase_debug", {phase, debug}, 34'd0);
      repeat (3) @(negedge S_AXI_ACLK);
      chk("midrst_no_done", done_cnt, 0);
      S_AXI_ARESETN = 1'b1;
      @(negedge S_AXI_ACLK);
      launch("postrst", 0, 0, 1, 20);
      wait_done("postrst");
      check_run("postrst", 0, 0, 1, 20);

      // randomized configurations with random handshake timing
      rand_ready = 1'b1;
      rand_dp    = 1'b1;
      for (int r = 0; r < 8; r++) begin
         ri = $urandom_range(0, 3);
         rt = $urandom_range(0, 3);
         re = $urandom_range(0, 3);
         rs = $urandom_range(0, 5);
         launch($sformatf("rand%0d", r), ri, rt, re, rs);
         wait_done($sformatf("rand%0d", r));
         check_run($sformatf("rand%0d", r), ri, rt, re, rs);
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/dfr_run_sequencer.md
Name: dfr_run_sequencer

Overview:
- Run controller for the DFR core. Launched by the control register's start bit.
- Walks the init, train and test phases sample by sample and step by step.
- Per step: reads the input memory, triggers one reservoir step, writes reservoir history. Per test sample: launches the output-layer dot product and writes the result to output memory.
- Pulses done so the register block clears CTRL bit 0; busy drives the top-level busy line.

Parameters:
- ADDR_WIDTH, 16, width of input, history and output memory word addresses (matches RESERVOIR_HISTORY_ADDR_WIDTH).
- CNT_WIDTH, 32, width of the sample and step count configuration registers.

Ports:
- S_AXI_ACLK  in  1  clock.
- S_AXI_ARESETN  in  1  reset; synchronous, active-low.
- start  in  1  CTRL reg bit 0 (level).
- num_init_samples  in  CNT_WIDTH  init-phase sample count.
- num_train_samples  in  CNT_WIDTH  train-phase sample count.
- num_test_samples  in  CNT_WIDTH  test-phase sample count.
- num_steps_per_sample  in  CNT_WIDTH  steps per sample.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at run end.
- in_mem_rd  out  1  input memory read strobe.
- in_mem_addr  out  ADDR_WIDTH  input word address.
- res_step_valid  out  1  request one reservoir step.
- res_step_ready  in  1  reservoir accepted/completed the step.
- hist_wr  out  1  reservoir history write strobe.
- hist_addr  out  ADDR_WIDTH  history word address.
- dp_start  out  1  one-cycle dot-product launch.
- dp_done  in  1  dot-product result valid.
- out_mem_wr  out  1  output memory write strobe.
- out_mem_addr  out  ADDR_WIDTH  output word address.
- phase  out  2  0 idle, 1 init, 2 train, 3 test.
- debug  out  32  {state[3:0], err, 11'b0, test sample idx[15:0]}.

Behaviour:
- Reset: all outputs 0; FSM to IDLE; counters 0; start-edge register 0. A reset mid-run aborts with no done pulse.
- Launch: a rising edge of start (registered start was 0, now 1) in IDLE is sampled at cycle N.
  - N+1: busy=1, state LATCH. All count inputs are captured; later changes are ignored until the next run.
  - A level-high start after done does not relaunch. Start must fall and rise again.
- FSM: IDLE -> LATCH -> RD -> STEP -> (DP -> DP_WAIT -> OUT_WR) -> DONE -> IDLE.
- LATCH:
  - steps_per_sample==0 with a nonzero total sample count: DONE with err=1.
  - Total samples==0: DONE with err=0.
  - Otherwise: RD, with phase set to the first phase with nonzero samples.
- RD: in_mem_rd=1 for one cycle; in_mem_addr = global step index (counts across all phases, modulo 2^ADDR_WIDTH). Next cycle: STEP (one-cycle memory latency).
- STEP:
  - res_step_valid=1, held until res_step_ready. Addresses stay stable while waiting.
  - On handshake in train or test phase: hist_wr pulses in the same cycle. hist_addr = global step minus init steps.
  - Init phase: no history write.
  - Then advance the step counter:
    - Not the last step of the sample: RD.
    - Last step in test phase: DP.
    - Last step otherwise: next sample. The sample counter wraps to 0 at a phase boundary and moves phase init->train->test, skipping zero-count phases.
- DP: dp_start pulses one cycle, then DP_WAIT until dp_done.
- OUT_WR: out_mem_wr=1 for one cycle, out_mem_addr = test sample index. Then RD for the next sample, or DONE after the last test sample.
- DONE: done=1 for one cycle. busy falls the same cycle, phase=0, then IDLE.
- Simultaneous events: dp_done and res_step_ready are ignored outside DP_WAIT and STEP.
- Counters are CNT_WIDTH. The step-count product is not checked for overflow; addresses wrap silently.

Optional Feature:
- Macro DFR_SEQ_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit). abort=1 in any non-IDLE state forces DONE on the next cycle, with err=1 and debug bit 27 set.
  - Any in-flight res_step_valid is dropped.
- Undefined: the port is absent and a run always completes.

Decomposition:
- Package dfr_pkg:
  - state_t enum.
  - phase_t enum with IDLE/INIT/TRAIN/TEST = 0..3.
  - DFR_ADDR_WIDTH default.
  - Debug bit-position constants.
- Sub-module dfr_step_counter: nested sample/step counter with load, inc, last_step and last_sample flags. Instanced once; phase logic stays in the parent.

Test Plan:
- init=0 train=0 test=1 steps=100:
  - in_mem_addr 0..99; hist_addr 0..99 (100 writes).
  - One dp_start after step 99, then out_mem_wr addr 0.
  - done pulse; busy low.
- init=1 train=0 test=2 steps=4:
  - in_mem_addr 0..11; hist writes only for global steps 4..11, at hist_addr 0..7.
  - phase 1 then 3; dp_start x2; out_mem_addr 0 then 1.
- All counts 0: done at N+2, err=0, no in_mem_rd/hist_wr. steps=0 with test=1: done at N+2, err=1.
- res_step_ready low for 50 cycles at step 5: res_step_valid held, in_mem_addr=5 and hist_addr=5 stable, no extra strobes.
- Reset mid-run at step 37: all outputs 0 next cycle, no done. Relaunch starts at in_mem_addr 0.
- Start held high after done: no relaunch. Start low 1 cycle then high: new run.
